// File: rtl/dco_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dco_ctrl_pkg
// Shared DCO control definitions, reused by the word sequencer and the loop
// filter: sequencer state encoding and default tuning constants.
// ---------------------------------------------------------------------------
package dco_ctrl_pkg;

   // Sequencer state encoding, kept as plain constants so that older blocks
   // which compare raw state bits stay compatible.
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RAMP = 1'b1;

   // Default largest word change per update and update-interval field width.
   localparam int STEP_MAX_DEF = 4;
   localparam int PERIOD_W_DEF = 4;

endpackage : dco_ctrl_pkg

// File: rtl/dco_tick_timer.sv
// ---------------------------------------------------------------------------
// dco_tick_timer
// Loadable down-counter that sets the update cadence of the DCO sequencer.
// While running it counts down to zero; the cycle in which it sits at zero is
// a tick, and on that edge it reloads from period, so ticks arrive every
// period+1 running cycles. hold freezes the count without losing it.
//
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-low reset (count -> 0)
//   load    in   load count from period (takes priority over counting)
//   run     in   counter enabled
//   hold    in   freeze the count, suppress tick
//   period  in   reload value (interval minus 1)
//   tick    out  combinational, high in the cycle a step is due
// ---------------------------------------------------------------------------
module dco_tick_timer #(
   parameter int PERIOD_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic                run,
   input  logic                hold,
   input  logic [PERIOD_W-1:0] period,
   output logic                tick
);

   logic [PERIOD_W-1:0] cnt;

   assign tick = run && !hold && (cnt == '0);

   // NOTE: state registers use non-blocking assignments only, and the reset
   // branch is inside the clocked block because the reset is synchronous.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= period;
      end else if (run && !hold) begin
         if (cnt == '0) begin
            cnt <= period;
         end else begin
            cnt <= cnt - 1'b1;
         end
      end
   end

endmodule : dco_tick_timer

// File: rtl/dco_word_seq.sv
// ---------------------------------------------------------------------------
// dco_word_seq
// Sequencer between the loop filter and the DCO row/column capacitor coder.
// A new target word is taken through a valid/ready handshake; the applied
// word then slews toward it in steps of at most STEP_MAX, one step per update
// interval (period+1 cycles), so the capacitor array never jumps by a large
// code. word_en strobes for one cycle whenever word takes a new value.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-low reset
//   tgt_word   in   target, integer [WORD_W+FRAC_W-1:FRAC_W], fraction below
//   tgt_valid  in   target offered
//   tgt_ready  out  target can be accepted (high in IDLE)
//   period     in   update interval minus 1, sampled on accept and reload
//   hold       in   freezes interval counter and stepping
//   word       out  applied tuning word (registered)
//   word_en    out  one-cycle strobe, high while word holds a new value
//   busy       out  high while ramping
//
// Build option: define DCO_WORD_DITHER_EN to dither word between target and
// target+1 in IDLE using the fractional part of the target. Without it the
// fraction is ignored.
// ---------------------------------------------------------------------------
module dco_word_seq
   import dco_ctrl_pkg::*;
#(
   parameter int WORD_W   = 8,
   parameter int FRAC_W   = 4,
   parameter int STEP_MAX = STEP_MAX_DEF,
   parameter int PERIOD_W = PERIOD_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WORD_W+FRAC_W-1:0] tgt_word,
   input  logic                     tgt_valid,
   output logic                     tgt_ready,
   input  logic [PERIOD_W-1:0]      period,
   input  logic                     hold,
   output logic [WORD_W-1:0]        word,
   output logic                     word_en,
   output logic                     busy
);

   localparam logic [WORD_W-1:0] STEP_W   = WORD_W'(STEP_MAX);
   localparam logic [WORD_W:0]   STEP_EXT = (WORD_W+1)'(STEP_MAX);

   logic [0:0]        state;
   logic [WORD_W-1:0] target;
   logic [WORD_W-1:0] tgt_int;
   logic              accept;
   logic              tick;
   logic              timer_run;

   // Step computation
   logic signed [WORD_W:0] diff;
   logic [WORD_W:0]        abs_diff;
   logic                   close;
   logic [WORD_W-1:0]      step_word;

   assign tgt_int   = tgt_word[WORD_W+FRAC_W-1:FRAC_W];
   assign tgt_ready = (state == ST_IDLE);
   assign busy      = (state == ST_RAMP);
   assign accept    = tgt_valid && tgt_ready;

   // NOTE: every signal written here gets a value on every path, starting
   // with defaults, so no latch is inferred.
   always_comb begin
      diff      = $signed({1'b0, target}) - $signed({1'b0, word});
      abs_diff  = diff[WORD_W] ? WORD_W'(0) - diff : diff;
      close     = (abs_diff <= STEP_EXT);
      step_word = word;
      if (close) begin
         // Last step is clipped onto the target, so word never overshoots
         // or wraps.
         step_word = target;
      end else if (diff[WORD_W]) begin
         step_word = word - STEP_W;
      end else begin
         step_word = word + STEP_W;
      end
   end

`ifdef DCO_WORD_DITHER_EN
   logic [FRAC_W-1:0] frac;
   logic [FRAC_W-1:0] acc;
   logic [FRAC_W:0]   acc_sum;
   logic [WORD_W-1:0] dith_word;

   // The counter also paces the dither in IDLE when there is a fraction.
   assign timer_run = (state == ST_RAMP) || (frac != '0);
   assign acc_sum   = {1'b0, acc} + {1'b0, frac};
   // At all-ones the carry would wrap the word, so it is dropped there.
   assign dith_word = (&target) ? target : target + WORD_W'(acc_sum[FRAC_W]);
`else
   assign timer_run = (state == ST_RAMP);
   logic unused_frac;
   assign unused_frac = ^tgt_word[FRAC_W-1:0];
`endif

   dco_tick_timer #(
      .PERIOD_W (PERIOD_W)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (accept),
      .run    (timer_run),
      .hold   (hold),
      .period (period),
      .tick   (tick)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= ST_IDLE;
         target  <= '0;
         word    <= '0;
         word_en <= 1'b0;
`ifdef DCO_WORD_DITHER_EN
         frac    <= '0;
         acc     <= '0;
`endif
      end else begin
         word_en <= 1'b0;
         if (accept) begin
            target <= tgt_int;
`ifdef DCO_WORD_DITHER_EN
            frac   <= tgt_word[FRAC_W-1:0];
            acc    <= '0;
`endif
            if (tgt_int != word) begin
               state <= ST_RAMP;
            end
         end else if ((state == ST_RAMP) && tick) begin
            word    <= step_word;
            word_en <= 1'b1;
            if (close) begin
               state <= ST_IDLE;
            end
         end
`ifdef DCO_WORD_DITHER_EN
         else if ((state == ST_IDLE) && tick) begin
            acc     <= acc_sum[FRAC_W-1:0];
            word    <= dith_word;
            word_en <= (dith_word != word);
         end
`endif
      end
   end

endmodule : dco_word_seq

// File: tb/tb_dco_word_seq.sv
// ---------------------------------------------------------------------------
// tb_dco_word_seq
// Self-checking bench for dco_word_seq (default build, WORD_W=8, FRAC_W=4,
// STEP_MAX=4). Directed scenarios for reset, up/down ramps, hold, same
// target and reset mid-ramp, then a randomized run against a behavioural
// model that tracks the word, the target and the number of un-held cycles
// left before the next step.
// ---------------------------------------------------------------------------
module tb_dco_word_seq;

   localparam int WORD_W   = 8;
   localparam int FRAC_W   = 4;
   localparam int STEP_MAX = 4;
   localparam int PERIOD_W = 4;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [WORD_W+FRAC_W-1:0] tgt_word;
   logic                     tgt_valid;
   logic                     tgt_ready;
   logic [PERIOD_W-1:0]      period;
   logic                     hold;
   logic [WORD_W-1:0]        word;
   logic                     word_en;
   logic                     busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dco_word_seq #(
      .WORD_W   (WORD_W),
      .FRAC_W   (FRAC_W),
      .STEP_MAX (STEP_MAX),
      .PERIOD_W (PERIOD_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .tgt_word  (tgt_word),
      .tgt_valid (tgt_valid),
      .tgt_ready (tgt_ready),
      .period    (period),
      .hold      (hold),
      .word      (word),
      .word_en   (word_en),
      .busy      (busy)
   );

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   // Offer a target for one edge (edge 0 of the scenario).
   task automatic offer(input int integer_part, input int frac_part, input int per);
      tgt_word  = {WORD_W'(integer_part), FRAC_W'(frac_part)};
      period    = PERIOD_W'(per);
      tgt_valid = 1'b1;
      tick();
      tgt_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; tgt_valid = 1'b0; tgt_word = '0; period = '0; hold = 1'b0;
      tick();
      tick();
      checks++;
      if (word !== 8'd0 || word_en !== 1'b0 || tgt_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset: word=%0d en=%b ready=%b busy=%b, want 0 0 1 0",
                  word, word_en, tgt_ready, busy);
      end
      rst = 1'b1;
   endtask

   task automatic test_up_ramp();
      int exp_w;
      do_reset();
      offer(10, 0, 2);
      for (int e = 1; e <= 11; e++) begin
         tick();
         exp_w = (e >= 9) ? 10 : (e >= 6) ? 8 : (e >= 3) ? 4 : 0;
         checks++;
         if (word !== 8'(exp_w) || word_en !== (e == 3 || e == 6 || e == 9) ||
             tgt_ready !== (e >= 9) || busy !== (e < 9)) begin
            errors++;
            $display("FAIL up_ramp edge %0d: word=%0d en=%b ready=%b busy=%b, want word=%0d en=%b ready=%b busy=%b",
                     e, word, word_en, tgt_ready, busy, exp_w,
                     (e == 3 || e == 6 || e == 9), (e >= 9), (e < 9));
         end
      end
   endtask

   // Continues from word=10 left by the up ramp.
   task automatic test_down_ramp();
      int exp_w;
      offer(3, 0, 0);
      for (int e = 1; e <= 3; e++) begin
         tick();
         exp_w = (e == 1) ? 6 : 3;
         checks++;
         if (word !== 8'(exp_w) || word_en !== (e <= 2) ||
             tgt_ready !== (e >= 2) || busy !== (e < 2)) begin
            errors++;
            $display("FAIL down_ramp edge %0d: word=%0d en=%b ready=%b busy=%b, want word=%0d en=%b ready=%b busy=%b",
                     e, word, word_en, tgt_ready, busy, exp_w, (e <= 2), (e >= 2), (e < 2));
         end
      end
   endtask

   task automatic test_hold();
      int exp_w;
      do_reset();
      offer(10, 0, 2);
      for (int e = 1; e <= 15; e++) begin
         // hold is seen by edges 4..8
         hold = (e >= 4 && e <= 8);
         tick();
         hold = 1'b0;
         exp_w = (e >= 14) ? 10 : (e >= 11) ? 8 : (e >= 3) ? 4 : 0;
         checks++;
         if (word !== 8'(exp_w) || word_en !== (e == 3 || e == 11 || e == 14) ||
             busy !== (e < 14)) begin
            errors++;
            $display("FAIL hold edge %0d: word=%0d en=%b busy=%b, want word=%0d en=%b busy=%b",
                     e, word, word_en, busy, exp_w, (e == 3 || e == 11 || e == 14), (e < 14));
         end
      end
   endtask

   // Continues from word=10 left by the hold scenario.
   task automatic test_same_target();
      offer(10, 0, 1);
      for (int e = 0; e <= 4; e++) begin
         if (e > 0) tick();
         checks++;
         if (word !== 8'd10 || word_en !== 1'b0 || tgt_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL same_target edge %0d: word=%0d en=%b ready=%b busy=%b, want 10 0 1 0",
                     e, word, word_en, tgt_ready, busy);
         end
      end
   endtask

   task automatic test_reset_mid_ramp();
      int exp_w;
      do_reset();
      offer(10, 0, 2);
      for (int e = 1; e <= 12; e++) begin
         rst = (e != 5);
         tick();
         rst = 1'b1;
         exp_w = (e == 3 || e == 4) ? 4 : 0;
         checks++;
         if (word !== 8'(exp_w) || word_en !== (e == 3) ||
             tgt_ready !== (e >= 5) || busy !== (e < 5)) begin
            errors++;
            $display("FAIL reset_mid_ramp edge %0d: word=%0d en=%b ready=%b busy=%b, want word=%0d en=%b ready=%b busy=%b",
                     e, word, word_en, tgt_ready, busy, exp_w, (e == 3), (e >= 5), (e < 5));
         end
      end
   endtask

   // Behavioural model: word, target, ramping flag and un-held cycles left
   // until the next step (interval = period+1).
   int m_word, m_tgt, m_wait;
   bit m_ramp, m_en;

   task automatic model_edge(input bit r, input bit v, input int tw, input int per, input bit h);
      int d;
      m_en = 1'b0;
      if (!r) begin
         m_word = 0; m_tgt = 0; m_wait = 0; m_ramp = 1'b0;
      end else if (!m_ramp) begin
         if (v) begin
            m_tgt  = tw >> FRAC_W;
            m_wait = per + 1;
            m_ramp = (m_tgt != m_word);
         end
      end else if (!h) begin
         m_wait--;
         if (m_wait == 0) begin
            d = m_tgt - m_word;
            if (d <= STEP_MAX && d >= -STEP_MAX) begin
               m_word = m_tgt;
               m_ramp = 1'b0;
            end else begin
               m_word = m_word + ((d > 0) ? STEP_MAX : -STEP_MAX);
            end
            m_en   = 1'b1;
            m_wait = per + 1;
         end
      end
   endtask

   task automatic test_random();
      bit r, v, h;
      int tw, per;
      for (int i = 0; i < 400; i++) begin
         r   = (i == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
         v   = ($urandom_range(0, 3) == 0);
         tw  = int'($urandom_range(0, (1 << (WORD_W + FRAC_W)) - 1));
         per = int'($urandom_range(0, 3));
         h   = ($urandom_range(0, 4) == 0);
         rst = r; tgt_valid = v; tgt_word = (WORD_W+FRAC_W)'(tw);
         period = PERIOD_W'(per); hold = h;
         tick();
         model_edge(r, v, tw, per, h);
         checks++;
         if (word !== 8'(m_word) || word_en !== m_en ||
             tgt_ready !== !m_ramp || busy !== m_ramp) begin
            errors++;
            $display("FAIL random cycle %0d: word=%0d en=%b ready=%b busy=%b, want word=%0d en=%b ready=%b busy=%b",
                     i, word, word_en, tgt_ready, busy, m_word, m_en, !m_ramp, m_ramp);
         end
      end
      rst = 1'b1; tgt_valid = 1'b0; hold = 1'b0;
   endtask

   initial begin
      test_reset();
      test_up_ramp();
      test_down_ramp();
      test_hold();
      test_same_target();
      test_reset_mid_ramp();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_dco_word_seq
